battle_sequencer: RTL and testbench

Turn-based controller for the battle screen. Sequences the attack phase (moving bar sweeps across the fight frame and is stopped by a UART key), scores the stop position against the coloured score-bar zones, runs the timed dodge phase inside the escape frame, and owns both HP counters. It feeds the HP bars, the moving bar and the frame-select mux, and shares the UART transmitter for win/lose status bytes.

---
 rtl/battle_pkg.sv | 44 ++++
 rtl/score_zone.sv | 24 ++
 rtl/battle_sequencer.sv | 166 ++++++++++++++++
 tb/tb_battle_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
`default_nettype none
// battle_pkg: phase encoding, score-bar zone bounds, damage values and status bytes.
package battle_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FIGHT = 3'd1,
        PH_SCORE = 3'd2,
        PH_DODGE = 3'd3,
        PH_WIN   = 3'd4,
        PH_LOSE  = 3'd5
    } phase_t;

    localparam logic [15:0] GREEN_LO    = 16'd305;
    localparam logic [15:0] GREEN_HI    = 16'd325;
    localparam logic [15:0] YELLOW_L_LO = 16'd220;
    localparam logic [15:0] YELLOW_L_HI = 16'd235;
    localparam logic [15:0] YELLOW_R_LO = 16'd395;
    localparam logic [15:0] YELLOW_R_HI = 16'd410;
    localparam logic [15:0] ORANGE_L_LO = 16'd160;
    localparam logic [15:0] ORANGE_L_HI = 16'd175;
    localparam logic [15:0] ORANGE_R_LO = 16'd455;
    localparam logic [15:0] ORANGE_R_HI = 16'd470;
    localparam logic [15:0] BLUE_L_LO   = 16'd115;
    localparam logic [15:0] BLUE_L_HI   = 16'd130;
    localparam logic [15:0] BLUE_R_LO   = 16'd500;
    localparam logic [15:0] BLUE_R_HI   = 16'd515;

    localparam logic [7:0] DMG_GREEN  = 8'd50;
    localparam logic [7:0] DMG_YELLOW = 8'd30;
    localparam logic [7:0] DMG_ORANGE = 8'd20;
    localparam logic [7:0] DMG_BLUE   = 8'd10;
    localparam logic [7:0] DMG_NONE   = 8'd0;

    localparam logic [7:0] STATUS_WIN  = 8'h57;
    localparam logic [7:0] STATUS_LOSE = 8'h4C;

    function automatic logic in_zone(input logic [15:0] x, input logic [15:0] lo,
                                     input logic [15:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_zone.sv
`default_nettype none
// score_zone: maps a bar x position to the damage of the score-bar zone it lands in.
module score_zone
    import battle_pkg::*;
(
    input  logic [15:0] x,
    output logic [7:0]  damage
);

    // Zones are tested from the centre outwards so the first match wins.
    always_comb begin
        damage = DMG_NONE;
        if (in_zone(x, GREEN_LO, GREEN_HI))
            damage = DMG_GREEN;
        else if (in_zone(x, YELLOW_L_LO, YELLOW_L_HI) || in_zone(x, YELLOW_R_LO, YELLOW_R_HI))
            damage = DMG_YELLOW;
        else if (in_zone(x, ORANGE_L_LO, ORANGE_L_HI) || in_zone(x, ORANGE_R_LO, ORANGE_R_HI))
            damage = DMG_ORANGE;
        else if (in_zone(x, BLUE_L_LO, BLUE_L_HI) || in_zone(x, BLUE_R_LO, BLUE_R_HI))
            damage = DMG_BLUE;
    end

endmodule
`default_nettype wire

// File: rtl/battle_sequencer.sv
`default_nettype none
// battle_sequencer: turn FSM for the battle screen (attack bar, scoring, dodge, HP, status TX).
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int         PLAYER_HP     = 300,
    parameter int         MONSTER_HP    = 500,
    parameter int         FIGHT_FRAMES  = 300,
    parameter int         DODGE_FRAMES  = 360,
    parameter int         HIT_DAMAGE    = 20,
    parameter int         INVULN_FRAMES = 30,
    parameter logic [7:0] KEY_CODE      = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_animate,
    input  logic        i_rx_receive,
    input  logic [7:0]  i_rx_data,
    input  logic [15:0] i_bar_x,
    input  logic        i_hit,
    input  logic        i_tx_idle,
    output logic [2:0]  o_phase,
    output logic [15:0] o_player_hp,
    output logic [15:0] o_monster_hp,
    output logic        o_bar_run,
    output logic        o_bar_restart,
    output logic        o_frame_sel,
    output logic [7:0]  o_last_damage,
    output logic        o_tx_transmit,
    output logic [7:0]  o_tx_data
);

    localparam logic [15:0] FIGHT_LAST = 16'(FIGHT_FRAMES - 1);
    localparam logic [15:0] DODGE_LAST = 16'(DODGE_FRAMES - 1);
    localparam logic [15:0] HIT_DMG    = 16'(HIT_DAMAGE);
    localparam logic [15:0] INVULN     = 16'(INVULN_FRAMES);

    phase_t      state;
    logic [15:0] frame_cnt;
    logic [15:0] inv_cnt;
    logic [15:0] latched_x;
    logic        miss;
    logic        tx_pending;

    logic [7:0]  zone_damage;
    logic [7:0]  score_damage;
    logic [15:0] monster_after;
    logic [15:0] player_after;
    logic        key;
    logic        hit_ok;

    score_zone u_score_zone (
        .x      (latched_x),
        .damage (zone_damage)
    );

    assign key           = i_rx_receive && (i_rx_data == KEY_CODE);
    assign hit_ok        = i_hit && (inv_cnt == 16'd0);
    assign score_damage  = miss ? DMG_NONE : zone_damage;
    assign monster_after = (o_monster_hp > {8'd0, score_damage}) ?
                           o_monster_hp - {8'd0, score_damage} : 16'd0;
    assign player_after  = (o_player_hp > HIT_DMG) ? o_player_hp - HIT_DMG : 16'd0;
    assign o_phase       = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= PH_IDLE;
            frame_cnt     <= 16'd0;
            inv_cnt       <= 16'd0;
            latched_x     <= 16'd0;
            miss          <= 1'b0;
            tx_pending    <= 1'b0;
            o_player_hp   <= 16'(PLAYER_HP);
            o_monster_hp  <= 16'(MONSTER_HP);
            o_bar_run     <= 1'b0;
            o_bar_restart <= 1'b0;
            o_frame_sel   <= 1'b0;
            o_last_damage <= 8'd0;
            o_tx_transmit <= 1'b0;
            o_tx_data     <= 8'd0;
        end else begin
            o_bar_restart <= 1'b0;
            o_tx_transmit <= 1'b0;
            if (tx_pending && i_tx_idle) begin
                o_tx_transmit <= 1'b1;
                tx_pending    <= 1'b0;
            end
            if (i_animate)
                frame_cnt <= frame_cnt + 16'd1;

            case (state)
                PH_IDLE: begin
                    if (key) begin
                        o_player_hp   <= 16'(PLAYER_HP);
                        o_monster_hp  <= 16'(MONSTER_HP);
                        o_bar_restart <= 1'b1;
                        o_bar_run     <= 1'b1;
                        o_frame_sel   <= 1'b0;
                        frame_cnt     <= 16'd0;
                        state         <= PH_FIGHT;
                    end
                end
                PH_FIGHT: begin
                    // A key arriving on the timeout frame still counts as a real stop.
                    if (key) begin
                        latched_x <= i_bar_x;
                        miss      <= 1'b0;
                        o_bar_run <= 1'b0;
                        frame_cnt <= 16'd0;
                        state     <= PH_SCORE;
                    end else if (i_animate && frame_cnt == FIGHT_LAST) begin
                        miss      <= 1'b1;
                        o_bar_run <= 1'b0;
                        frame_cnt <= 16'd0;
                        state     <= PH_SCORE;
                    end
                end
                PH_SCORE: begin
                    o_monster_hp  <= monster_after;
                    o_last_damage <= score_damage;
                    frame_cnt     <= 16'd0;
                    inv_cnt       <= 16'd0;
                    if (monster_after == 16'd0) begin
                        tx_pending <= 1'b1;
                        o_tx_data  <= STATUS_WIN;
                        state      <= PH_WIN;
                    end else begin
                        o_frame_sel <= 1'b1;
                        state       <= PH_DODGE;
                    end
                end
                PH_DODGE: begin
                    if (hit_ok) begin
                        o_player_hp <= player_after;
                        inv_cnt     <= INVULN;
                    end else if (i_animate && inv_cnt != 16'd0) begin
                        inv_cnt <= inv_cnt - 16'd1;
                    end
                    // Death takes priority over the end of the dodge window.
                    if (hit_ok && player_after == 16'd0) begin
                        tx_pending <= 1'b1;
                        o_tx_data  <= STATUS_LOSE;
                        frame_cnt  <= 16'd0;
                        state      <= PH_LOSE;
                    end else if (i_animate && frame_cnt == DODGE_LAST) begin
                        o_bar_restart <= 1'b1;
                        o_bar_run     <= 1'b1;
                        o_frame_sel   <= 1'b0;
                        frame_cnt     <= 16'd0;
                        state         <= PH_FIGHT;
                    end
                end
                PH_WIN, PH_LOSE: begin
                    if (key) begin
                        o_frame_sel <= 1'b0;
                        frame_cnt   <= 16'd0;
                        state       <= PH_IDLE;
                    end
                end
                default: state <= PH_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_battle_sequencer.sv
`default_nettype none
// tb_battle_sequencer: randomized scoreboard bench for battle_sequencer.
module tb_battle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        animate, rx_receive, hit, tx_idle;
    logic [7:0]  rx_data;
    logic [15:0] bar_x;
    logic [2:0]  phase;
    logic [15:0] player_hp, monster_hp;
    logic        bar_run, bar_restart, frame_sel, tx_transmit;
    logic [7:0]  last_damage, tx_data;

    always #5 clk = ~clk;

    battle_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_animate     (animate),
        .i_rx_receive  (rx_receive),
        .i_rx_data     (rx_data),
        .i_bar_x       (bar_x),
        .i_hit         (hit),
        .i_tx_idle     (tx_idle),
        .o_phase       (phase),
        .o_player_hp   (player_hp),
        .o_monster_hp  (monster_hp),
        .o_bar_run     (bar_run),
        .o_bar_restart (bar_restart),
        .o_frame_sel   (frame_sel),
        .o_last_damage (last_damage),
        .o_tx_transmit (tx_transmit),
        .o_tx_data     (tx_data)
    );

    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] php;
        logic [15:0] mhp;
        logic [7:0]  dmg;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] txq[$];
    int compared   = 0;
    int mismatched = 0;
    int m_php = 300;
    int m_mhp = 500;
    int m_dmg = 0;

    function automatic int zone_dmg(input int x);
        int lo[7];
        int hi[7];
        int dv[7];
        lo = '{305, 220, 395, 160, 455, 115, 500};
        hi = '{325, 235, 410, 175, 470, 130, 515};
        dv = '{ 50,  30,  30,  20,  20,  10,  10};
        for (int i = 0; i < 7; i++)
            if (x >= lo[i] && x <= hi[i]) return dv[i];
        return 0;
    endfunction

    task automatic push_ev(input int ph);
        evq.push_back('{3'(ph), 16'(m_php), 16'(m_mhp), 8'(m_dmg)});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every phase change is matched against the next expected event.
    initial begin : monitor
        logic [2:0] prev_ph;
        ev_t        e;
        logic       ok;
        prev_ph = 3'd0;
        forever begin
            @(negedge clk);
            if (phase !== prev_ph) begin
                compared++;
                if (evq.size() == 0) begin
                    mismatched++;
                    $display("FAIL phase_event: unexpected phase %0d, none expected", phase);
                end else begin
                    e  = evq.pop_front();
                    ok = (phase === e.ph) && (player_hp === e.php) &&
                         (monster_hp === e.mhp) && (last_damage === e.dmg);
                    if (e.ph == 3'd1) ok = ok && (bar_restart === 1'b1) && (bar_run === 1'b1) && (frame_sel === 1'b0);
                    if (e.ph == 3'd3) ok = ok && (bar_restart === 1'b0) && (bar_run === 1'b0) && (frame_sel === 1'b1);
                    if (!ok) begin
                        mismatched++;
                        $display("FAIL phase_event: got ph=%0d php=%0d mhp=%0d dmg=%0d rst=%b run=%b fsel=%b expected ph=%0d php=%0d mhp=%0d dmg=%0d",
                                 phase, player_hp, monster_hp, last_damage, bar_restart, bar_run, frame_sel,
                                 e.ph, e.php, e.mhp, e.dmg);
                    end
                end
                prev_ph = phase;
            end else if (bar_restart !== 1'b0) begin
                compared++;
                mismatched++;
                $display("FAIL restart_pulse: got %b in phase %0d expected 0", bar_restart, phase);
            end
            if (tx_transmit === 1'b1) begin
                compared++;
                if (txq.size() == 0) begin
                    mismatched++;
                    $display("FAIL tx_byte: got transmit of %h expected none", tx_data);
                end else begin
                    automatic logic [7:0] b = txq.pop_front();
                    if (tx_data !== b) begin
                        mismatched++;
                        $display("FAIL tx_byte: got %h expected %h", tx_data, b);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic a, input logic h);
        animate = a;
        hit     = h;
        @(negedge clk);
        animate = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] b, input int x);
        rx_receive = 1'b1;
        rx_data    = b;
        bar_x      = 16'(x);
        @(negedge clk);
        rx_receive = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (phase !== 3'(p) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (phase !== 3'(p)) begin
            compared++;
            mismatched++;
            $display("FAIL wait_phase: got %0d expected %0d", phase, p);
        end
    endtask

    task automatic score_expect(input int x, input bit is_miss);
        int d = is_miss ? 0 : zone_dmg(x);
        push_ev(2);
        m_mhp = (m_mhp > d) ? m_mhp - d : 0;
        m_dmg = d;
        push_ev(m_mhp == 0 ? 4 : 3);
    endtask

    task automatic frame_idle();
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic fight_key(input int pre, input int x);
        repeat (pre) frame_idle();
        score_expect(x, 1'b0);
        send_key(8'h20, x);
        wait_phase(m_mhp == 0 ? 4 : 3, 10);
    endtask

    task automatic fight_timeout(input bit with_key, input int x);
        repeat (299) frame_idle();
        repeat (3) cyc(1'b0, 1'b0);
        score_expect(x, !with_key);
        animate = 1'b1;
        if (with_key) send_key(8'h20, x);
        else begin bar_x = 16'(x); @(negedge clk); end
        animate = 1'b0;
        wait_phase(3, 10);
    endtask

    // Hit is held for whole frames; a hit is accepted if 30+ frames since the last accepted one.
    task automatic dodge(input int h_lo, input int h_hi, input int den);
        int last = -1000;
        bit lost = 1'b0;
        bit h;
        for (int f = 0; f < 360; f++) begin
            h = (f >= h_lo && f <= h_hi) || (den > 0 && $urandom_range(den - 1) == 0);
            if (h && (f - last) >= 30) begin
                last  = f;
                m_php = (m_php > 20) ? m_php - 20 : 0;
                if (m_php == 0) begin
                    lost = 1'b1;
                    push_ev(5);
                    txq.push_back(8'h4C);
                end
            end
            if (!lost && f == 359) push_ev(1);
            repeat (3) cyc(1'b0, h);
            cyc(1'b1, h);
            if (lost) break;
        end
        hit = 1'b0;
        wait_phase(lost ? 5 : 1, 10);
    endtask

    task automatic start_game();
        m_php = 300;
        m_mhp = 500;
        push_ev(1);
        send_key(8'h20, 0);
        wait_phase(1, 5);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lo;
        rst_n = 1'b0; animate = 1'b0; rx_receive = 1'b0; rx_data = 8'd0;
        bar_x = 16'd0; hit = 1'b0; tx_idle = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase", phase, 0);
        chk("reset_player_hp", player_hp, 300);
        chk("reset_monster_hp", monster_hp, 500);
        chk("reset_outputs", {bar_run, bar_restart, frame_sel, tx_transmit}, 0);
        chk("reset_damage_tx", {last_damage, tx_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Game 1: wrong byte ignored, scoring boundaries, timeout, then win.
        send_key(8'h41, 0);
        repeat (3) cyc(1'b0, 1'b0);
        chk("idle_ignores_byte", phase, 0);
        start_game();
        fight_key(2, 310);
        dodge(0, 99, 0);
        fight_key(5, 236);
        lo = $urandom_range(0, 300);
        dodge(lo, lo + $urandom_range(0, 40), 0);
        fight_key(0, 515);
        dodge(1, 0, 0);
        fight_timeout(1'b0, $urandom_range(100, 530));
        dodge(1, 0, 0);
        fight_timeout(1'b1, $urandom_range(100, 530));
        lo = $urandom_range(0, 300);
        dodge(lo, lo + $urandom_range(0, 40), 0);
        repeat (3) begin
            fight_key($urandom_range(0, 20), $urandom_range(100, 530));
            lo = $urandom_range(0, 300);
            dodge(lo, lo + $urandom_range(0, 40), 0);
        end
        while (m_mhp > 40) begin
            fight_key(1, (m_mhp - 40 >= 50) ? $urandom_range(305, 325) : $urandom_range(500, 515));
            dodge(1, 0, 0);
        end
        fight_key(1, $urandom_range(305, 325));
        repeat (4) cyc(1'b0, 1'b0);
        chk("win_tx_held", tx_data, 8'h57);
        chk("win_tx_wait", tx_transmit, 0);
        txq.push_back(8'h57);
        tx_idle = 1'b1;
        repeat (4) cyc(1'b0, 1'b0);
        push_ev(0);
        send_key(8'h20, 0);
        wait_phase(0, 5);

        // Game 2: drain player HP to 20, then die on the last dodge frame.
        start_game();
        fight_key(1, $urandom_range(100, 530));
        dodge(0, 329, 0);
        fight_key(1, $urandom_range(100, 530));
        dodge(0, 60, 0);
        chk("player_hp_20", player_hp, 20);
        fight_key(1, $urandom_range(100, 530));
        dodge(359, 359, 0);
        repeat (4) cyc(1'b0, 1'b0);
        push_ev(0);
        send_key(8'h20, 0);
        wait_phase(0, 5);

        // Game 3: asynchronous reset in the middle of a dodge.
        start_game();
        fight_key(1, $urandom_range(100, 530));
        repeat (60) cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        hit = 1'b0;
        m_php = 300; m_mhp = 500; m_dmg = 0;
        push_ev(0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_phase", phase, 0);
        chk("async_hp", {player_hp, monster_hp}, {16'd300, 16'd500});
        chk("async_outputs", {bar_run, bar_restart, frame_sel, tx_transmit}, 0);
        chk("async_damage_tx", {last_damage, tx_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("events_left", evq.size(), 0);
        chk("tx_left", txq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
